// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant and binary index.
// Define RR_ARB_TIMEOUT_EN to compile in the MAX_HOLD grant-timeout counter.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       tout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("rr_arbiter_4: MAX_HOLD must be in 2..15");
  end

  state_t     state, state_next;
  logic [1:0] ptr, ptr_next;
  logic [1:0] idx_next;
  logic       tout_next;
  logic [3:0] gnt_next;
  logic       valid_next;

  // Returns {found, index} of the first set bit of r searching from p upward, wrapping 3 -> 0.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] cand;
    logic       found;
    logic [1:0] win;
    found = 1'b0;
    win   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = p + 2'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return {found, win};
  endfunction

  logic [2:0] pick_any;
  assign pick_any = pick(req, ptr);

`ifdef RR_ARB_TIMEOUT_EN
  logic [3:0] hold_cnt, hold_cnt_next;
  logic [3:0] others;
  logic [2:0] pick_other;

  assign others     = req & ~(4'b0001 << gnt_idx);
  assign pick_other = pick(others, ptr);
`endif

  // State register; outputs are registered alongside it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      tout      <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      gnt       <= gnt_next;
      gnt_idx   <= idx_next;
      gnt_valid <= valid_next;
      tout      <= tout_next;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt <= 4'd0;
    else     hold_cnt <= hold_cnt_next;
  end
`endif

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_next = state;
    ptr_next   = ptr;
    idx_next   = gnt_idx;
    tout_next  = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_next = 4'd0;
`endif
    unique case (state)
      IDLE: begin
        idx_next = 2'd0;
        if (pick_any[2]) begin
          state_next = GRANT;
          idx_next   = pick_any[1:0];
          ptr_next   = pick_any[1:0] + 2'd1;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          // Holder released: hand over without an idle cycle if anyone is waiting.
          if (pick_any[2]) begin
            idx_next = pick_any[1:0];
            ptr_next = pick_any[1:0] + 2'd1;
          end else begin
            state_next = IDLE;
            idx_next   = 2'd0;
          end
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          if (hold_cnt == 4'(MAX_HOLD - 1)) begin
            // Expiry: revoke only when someone else wants the resource; else restart the count.
            if (pick_other[2]) begin
              idx_next  = pick_other[1:0];
              ptr_next  = pick_other[1:0] + 2'd1;
              tout_next = 1'b1;
            end
          end else begin
            hold_cnt_next = hold_cnt + 4'd1;
          end
`endif
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 2'd0;
      end
    endcase
  end

  // Output decode of the next registered values.
  always_comb begin
    valid_next = (state_next == GRANT);
    gnt_next   = valid_next ? (4'b0001 << idx_next) : 4'b0000;
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4; timeout scenarios run when RR_ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       tout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .tout      (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed {gnt, gnt_idx, gnt_valid, tout} expected for holder h.
  function automatic logic [7:0] exp_hold(input int h, input logic t);
    logic [3:0] g;
    g = 4'b0001 << h;
    return {g, 2'(h), 1'b1, t};
  endfunction

  localparam logic [7:0] EXP_IDLE = 8'b0000_00_0_0;

  function automatic logic [7:0] observed();
    return {gnt, gnt_idx, gnt_valid, tout};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #4;
  endtask

  task automatic test_reset();
    req = 4'b0000;
    rst = 1'b1;
    #1;
    checks++;
    if (observed() !== EXP_IDLE) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", observed(), EXP_IDLE);
    end
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (observed() !== EXP_IDLE) begin
        errors++;
        $display("FAIL idle_no_req cycle %0d: got %b expected %b", i, observed(), EXP_IDLE);
      end
    end
  endtask

  task automatic test_rotation();
    apply_reset();
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (observed() !== exp_hold(k % 4, 1'b0)) begin
        errors++;
        $display("FAIL rotate_first k=%0d: got %b expected %b", k, observed(), exp_hold(k % 4, 1'b0));
      end
      req = 4'b1111;
      step();
      checks++;
      if (observed() !== exp_hold(k % 4, 1'b0)) begin
        errors++;
        $display("FAIL rotate_hold k=%0d: got %b expected %b", k, observed(), exp_hold(k % 4, 1'b0));
      end
      req = 4'b1111 & ~(4'b0001 << (k % 4));
      step();
    end
    req = 4'b0000;
  endtask

  task automatic test_single_release();
    apply_reset();
    req = 4'b0100;
    step();
    checks++;
    if (observed() !== exp_hold(2, 1'b0)) begin
      errors++;
      $display("FAIL single_grant: got %b expected %b", observed(), exp_hold(2, 1'b0));
    end
    req = 4'b0000;
    step();
    checks++;
    if (observed() !== EXP_IDLE) begin
      errors++;
      $display("FAIL single_release: got %b expected %b", observed(), EXP_IDLE);
    end
    req = 4'b1011;
    step();
    checks++;
    if (observed() !== exp_hold(3, 1'b0)) begin
      errors++;
      $display("FAIL ptr_after_idle: got %b expected %b", observed(), exp_hold(3, 1'b0));
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_mid_grant_reset();
    apply_reset();
    req = 4'b0010;
    step();
    checks++;
    if (observed() !== exp_hold(1, 1'b0)) begin
      errors++;
      $display("FAIL pre_reset_grant: got %b expected %b", observed(), exp_hold(1, 1'b0));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (observed() !== EXP_IDLE) begin
      errors++;
      $display("FAIL async_reset_drop: got %b expected %b", observed(), EXP_IDLE);
    end
    #1 rst = 1'b0;
    req = 4'b1010;
    step();
    checks++;
    if (observed() !== exp_hold(1, 1'b0)) begin
      errors++;
      $display("FAIL ptr_reset: got %b expected %b", observed(), exp_hold(1, 1'b0));
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_non_holder_noise();
    apply_reset();
    req = 4'b0001;
    step();
    req = 4'b1111;
    step();
    req = 4'b0101;
    step();
    checks++;
    if (observed() !== exp_hold(0, 1'b0)) begin
      errors++;
      $display("FAIL noise_ignored: got %b expected %b", observed(), exp_hold(0, 1'b0));
    end
    req = 4'b0100;
    step();
    checks++;
    if (observed() !== exp_hold(2, 1'b0)) begin
      errors++;
      $display("FAIL handover_after_noise: got %b expected %b", observed(), exp_hold(2, 1'b0));
    end
    req = 4'b0000;
    step();
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    req = 4'b0011;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (observed() !== exp_hold(0, 1'b0)) begin
        errors++;
        $display("FAIL timeout_hold cycle %0d: got %b expected %b", i, observed(), exp_hold(0, 1'b0));
      end
    end
    step();
    checks++;
    if (observed() !== exp_hold(1, 1'b1)) begin
      errors++;
      $display("FAIL timeout_switch: got %b expected %b", observed(), exp_hold(1, 1'b1));
    end
    step();
    checks++;
    if (observed() !== exp_hold(1, 1'b0)) begin
      errors++;
      $display("FAIL timeout_pulse_end: got %b expected %b", observed(), exp_hold(1, 1'b0));
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_timeout_alone();
    apply_reset();
    req = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (observed() !== exp_hold(0, 1'b0)) begin
        errors++;
        $display("FAIL timeout_alone cycle %0d: got %b expected %b", i, observed(), exp_hold(0, 1'b0));
      end
    end
    req = 4'b0000;
    step();
  endtask
`else
  task automatic test_no_timeout();
    apply_reset();
    req = 4'b0011;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (observed() !== exp_hold(0, 1'b0)) begin
        errors++;
        $display("FAIL hold_forever cycle %0d: got %b expected %b", i, observed(), exp_hold(0, 1'b0));
      end
    end
    req = 4'b0000;
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_rotation();
    test_single_release();
    test_mid_grant_reset();
    test_non_holder_noise();
`ifdef RR_ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_alone();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
